// File: rtl/gate_stim_checker.sv
// rtl/gate_stim_checker.sv - sweeps a 2-input gate through all input vectors and checks its output
// Each vector is held for DWELL cycles and y is sampled on the last edge of the dwell window.
module gate_stim_checker #(
    parameter logic [3:0] TRUTH  = 4'b1110,
    parameter int         DWELL  = 10,
    parameter int         PASSES = 1,
    parameter int         ERRW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            a,
    output logic            b,
    input  logic            y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic [3:0]      fail_vec
);

    localparam int DW_EFF = (DWELL < 1) ? 1 : DWELL;
    localparam int PS_EFF = (PASSES < 1) ? 1 : PASSES;
    localparam int DCW    = (DW_EFF > 1) ? $clog2(DW_EFF) : 1;
    localparam int PCW    = (PS_EFF > 1) ? $clog2(PS_EFF) : 1;

    localparam logic [DCW-1:0] DWELL_LOAD = DCW'(DW_EFF - 1);
    localparam logic [PCW-1:0] PASS_LAST  = PCW'(PS_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      vec_q, vec_d;
    logic [DCW-1:0]  dwell_q, dwell_d;
    logic [PCW-1:0]  pcnt_q, pcnt_d;
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]      fail_vec_q, fail_vec_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            a_q, a_d;
    logic            b_q, b_d;

    logic            last_sample;
    logic            mismatch;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dwell_d     = dwell_q;
        pcnt_d      = pcnt_q;
        err_cnt_d   = err_cnt_q;
        fail_vec_d  = fail_vec_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        last_sample = 1'b0;
        mismatch    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d    = ST_DRIVE;
                    err_cnt_d  = '0;
                    fail_vec_d = 4'b0000;
                    pass_d     = 1'b0;
                    vec_d      = 2'd0;
                    dwell_d    = DWELL_LOAD;
                    pcnt_d     = '0;
                end
            end

            ST_DRIVE: begin
                if (dwell_q == '0) begin
                    // End of the dwell window: y has had the whole window to settle
                    mismatch = (y != TRUTH[vec_q]);
                    if (mismatch) begin
                        fail_vec_d[vec_q] = 1'b1;
                        if (err_cnt_q != {ERRW{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERRW'(1);
                        end
                    end
                    dwell_d = DWELL_LOAD;
                    vec_d   = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        if (pcnt_q != PASS_LAST) begin
                            pcnt_d = pcnt_q + PCW'(1);
                        end else begin
                            last_sample = 1'b1;
                        end
                    end
                end else begin
                    dwell_d = dwell_q - DCW'(1);
                end

                // Abort takes priority over completing the run
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_sample) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE);
        a_d    = busy_d & vec_d[1];
        b_d    = busy_d & vec_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= 2'd0;
            dwell_q    <= '0;
            pcnt_q     <= '0;
            err_cnt_q  <= '0;
            fail_vec_q <= 4'b0000;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            dwell_q    <= dwell_d;
            pcnt_q     <= pcnt_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            a_q        <= a_d;
            b_q        <= b_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// tb/tb_gate_stim_checker.sv - randomized bench for gate_stim_checker against a sweep-level reference model
module tb_gate_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       go;
    logic       abrt;
    int         sel;
    logic [2:0] start_v, abort_v, y_v;
    logic [2:0] a_v, b_v, busy_v, done_v, pass_v;
    logic [3:0] fv0, fv1, fv2;
    logic [7:0] err0, err2;
    logic [1:0] err1;

    int n_checks = 0;
    int n_pass   = 0;

    assign start_v = go   ? (3'b001 << sel) : 3'b000;
    assign abort_v = abrt ? (3'b001 << sel) : 3'b000;

    gate_stim_checker #(.TRUTH(4'b1110), .DWELL(10), .PASSES(1), .ERRW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .a(a_v[0]), .b(b_v[0]), .y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_cnt(err0), .fail_vec(fv0));

    gate_stim_checker #(.TRUTH(4'b1110), .DWELL(0), .PASSES(4), .ERRW(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .a(a_v[1]), .b(b_v[1]), .y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_cnt(err1), .fail_vec(fv1));

    gate_stim_checker #(.TRUTH(4'b0110), .DWELL(3), .PASSES(3), .ERRW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .a(a_v[2]), .b(b_v[2]), .y(y_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_cnt(err2), .fail_vec(fv2));

    logic       ca, cb, cbusy, cdone, cpass;
    logic [7:0] cerr;
    logic [3:0] cfv;

    always_comb begin
        ca    = a_v[sel];
        cb    = b_v[sel];
        cbusy = busy_v[sel];
        cdone = done_v[sel];
        cpass = pass_v[sel];
        cerr  = (sel == 0) ? err0 : (sel == 1) ? {6'b0, err1} : err2;
        cfv   = (sel == 0) ? fv0  : (sel == 1) ? fv1 : fv2;
    end

    // Configuration of each instance, as the reference model sees it
    function automatic int dw(input int s);
        return (s == 0) ? 10 : (s == 1) ? 1 : 3;
    endfunction
    function automatic int np(input int s);
        return (s == 0) ? 1 : (s == 1) ? 4 : 3;
    endfunction
    function automatic logic [3:0] tr(input int s);
        return (s == 2) ? 4'b0110 : 4'b1110;
    endfunction
    function automatic int emax(input int s);
        return (s == 1) ? 3 : 255;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // fn is the gate the DUT drives (indexed by {a,b}); stop_at>0 aborts (or resets) in that cycle
    task automatic run(input int s, input logic [3:0] fn, input bit glitch,
                       input int stop_at, input bit use_rst, input int start_mid);
        int         d, total, pos, v, e_err;
        logic [3:0] e_fv, t;
        logic       val;
        bit         stopped, seen;
        sel     = s;
        d       = dw(s);
        total   = 4 * np(s) * d;
        t       = tr(s);
        e_err   = 0;
        e_fv    = 4'b0000;
        stopped = 1'b0;
        y_v     = 3'b000;
        @(negedge clk);
        go = 1'b1;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            go  = (c == start_mid);
            pos = (c - 1) % d;
            v   = ((c - 1) / d) % 4;
            if (pos == 0 && (v == 0 || $urandom_range(0, 1) == 0)) begin
                check("ab", {ca, cb}, v);
                check("busy", cbusy, 1);
            end
            val = fn[{ca, cb}];
            if (glitch && pos != d - 1 && $urandom_range(0, 2) == 0) val = ~val;
            y_v[s] = val;
            if (pos == d - 1 && fn[v] != t[v]) begin
                e_fv[v] = 1'b1;
                if (e_err < emax(s)) e_err++;
            end
            if (c == stop_at) begin
                go = 1'b0;
                if (use_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_busy", cbusy, 0);
                    check("rst_ab", {ca, cb}, 0);
                    check("rst_err", cerr, 0);
                    check("rst_fv", cfv, 0);
                    check("rst_done", cdone, 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    abrt = 1'b1;
                    @(negedge clk);
                    abrt = 1'b0;
                    check("abort_busy", cbusy, 0);
                    check("abort_ab", {ca, cb}, 0);
                    check("abort_pass", cpass, 0);
                    check("abort_err", cerr, e_err);
                    check("abort_fv", cfv, e_fv);
                    seen = cdone;
                    repeat (3) begin
                        @(negedge clk);
                        if (cdone) seen = 1'b1;
                    end
                    check("abort_no_done", seen, 0);
                end
                stopped = 1'b1;
                break;
            end
        end
        if (!stopped) begin
            @(negedge clk);
            go = 1'b0;
            check("done", cdone, 1);
            check("done_busy", cbusy, 0);
            check("done_ab", {ca, cb}, 0);
            check("pass", cpass, (e_err == 0) ? 1 : 0);
            check("err_cnt", cerr, e_err);
            check("fail_vec", cfv, e_fv);
            @(negedge clk);
            check("done_pulse", cdone, 0);
            check("pass_hold", cpass, (e_err == 0) ? 1 : 0);
            check("err_hold", cerr, e_err);
        end
        y_v = 3'b000;
    endtask

    initial begin
        int         s, tot, stop;
        logic [3:0] fn;
        rst_n = 1'b0;
        go    = 1'b0;
        abrt  = 1'b0;
        sel   = 0;
        y_v   = 3'b000;
        #1;
        check("reset_busy", busy_v, 0);
        check("reset_done", done_v, 0);
        check("reset_pass", pass_v, 0);
        check("reset_ab", {a_v, b_v}, 0);
        check("reset_err", {err0, err1, err2}, 0);
        check("reset_fv", {fv0, fv1, fv2}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(0, 4'b1110, 1'b0, 0, 1'b0, 0);   // correct OR gate
        run(0, 4'b0000, 1'b0, 0, 1'b0, 0);   // stuck at 0
        run(2, 4'b1111, 1'b0, 0, 1'b0, 5);   // stuck at 1, multi-pass, start ignored mid-run
        run(1, 4'b0001, 1'b0, 0, 1'b0, 0);   // NOR against OR, saturating 2-bit counter
        run(0, 4'b1111, 1'b0, 15, 1'b1, 0);  // asynchronous reset mid-run
        run(0, 4'b1110, 1'b1, 25, 1'b0, 7);  // abort, glitching OR gate

        sel = 0;
        @(negedge clk);
        go   = 1'b1;
        abrt = 1'b1;
        @(negedge clk);
        go   = 1'b0;
        abrt = 1'b0;
        check("start_abort_idle", busy_v[0], 0);
        @(negedge clk);
        check("start_abort_idle2", busy_v[0], 0);

        repeat (20) begin
            s   = $urandom_range(0, 2);
            fn  = 4'($urandom);
            tot = 4 * np(s) * dw(s);
            stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot) : 0;
            run(s, fn, 1'($urandom), stop, 1'b0, (stop == 0) ? $urandom_range(0, tot) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
